uart_frame_checker: RTL and testbench

Parametrised, synthesizable self-checking monitor for the system's serial output stream (SYS_OUT/SYS_VLD). It deserialises start/data/parity/stop frames, one bit per clock while valid is high, and compares each frame against a queue of expected words pushed by a host or sequencer. It reports per-frame pass/fail and keeps saturating pass/fail counters. It moves frame-level checking out of the bench and into reusable RTL for multi-width and multi-parity configurations.

---
 rtl/uart_frame_checker.sv | 201 ++++++++++++++++++++
 tb/tb_uart_frame_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_checker.sv
// Generic single-clock FIFO exposing its head word combinationally.
// Push/pop take effect on the next edge; a push is refused while full.
module uart_frame_checker_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [AW:0]   count_o,
    output logic          ready_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign ready_o = (count_q != (AW+1)'(DEPTH));
    assign push_ok = push_i && ready_o;
    assign pop_ok  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end
endmodule

// Serial frame monitor: deserialises start/data/parity/stop and checks against queued words.
// Result one cycle after the stop bit (or the abort edge); expected-word push stalls only when full.
module uart_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int EXP_DEPTH  = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int AW         = $clog2(EXP_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  par_en_i,
    input  logic                  par_typ_i,
    input  logic [DATA_WIDTH-1:0] exp_data_i,
    input  logic                  exp_valid_i,
    output logic                  exp_ready_o,
    output logic [AW:0]           exp_count_o,
    input  logic                  ser_in_i,
    input  logic                  ser_vld_i,
    input  logic                  clr_cnt_i,
    output logic                  frame_done_o,
    output logic                  frame_pass_o,
    output logic                  frame_abort_o,
    output logic [DATA_WIDTH-1:0] frame_data_o,
    output logic [CNT_WIDTH-1:0]  pass_cnt_o,
    output logic [CNT_WIDTH-1:0]  fail_cnt_o,
    output logic                  underrun_o
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  start_q, par_q, stop_q, par_en_q, par_typ_q;
    logic                  eval_q, abort_q;
    logic                  done_q, pass_q, frame_abort_q;
    logic [DATA_WIDTH-1:0] frame_data_q;
    logic [CNT_WIDTH-1:0]  pass_cnt_q, fail_cnt_q;
    logic                  underrun_q;

    logic [DATA_WIDTH-1:0] head;
    logic                  fifo_empty, par_ok, pass_d;

    uart_frame_checker_fifo #(.W(DATA_WIDTH), .DEPTH(EXP_DEPTH), .AW(AW)) u_exp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (exp_valid_i),
        .din_i   (exp_data_i),
        .pop_i   (eval_q),
        .head_o  (head),
        .count_o (exp_count_o),
        .ready_o (exp_ready_o)
    );

    // Evaluation runs one edge after the frame ends, so it reads the finished
    // frame's registers even when the next start bit is being captured.
    assign fifo_empty = (exp_count_o == '0);
    assign par_ok     = !par_en_q || (par_q == ((^data_q) ^ par_typ_q));
    assign pass_d     = !abort_q && !start_q && stop_q && !fifo_empty &&
                        (data_q == head) && par_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            data_q        <= '0;
            start_q       <= 1'b0;
            par_q         <= 1'b0;
            stop_q        <= 1'b0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            eval_q        <= 1'b0;
            abort_q       <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            frame_abort_q <= 1'b0;
            frame_data_q  <= '0;
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            underrun_q    <= 1'b0;
        end else begin
            eval_q <= 1'b0;
            done_q <= 1'b0;

            if (state_q != S_IDLE && !ser_vld_i) begin
                state_q <= S_IDLE;
                eval_q  <= 1'b1;
                abort_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: if (ser_vld_i) begin
                        start_q   <= ser_in_i;
                        par_en_q  <= par_en_i;
                        par_typ_q <= par_typ_i;
                        bit_cnt_q <= '0;
                        data_q    <= '0;
                        state_q   <= S_DATA;
                    end
                    S_DATA: begin
                        data_q[bit_cnt_q] <= ser_in_i;
                        bit_cnt_q         <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        par_q   <= ser_in_i;
                        state_q <= S_STOP;
                    end
                    default: begin
                        stop_q  <= ser_in_i;
                        eval_q  <= 1'b1;
                        abort_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end

            if (eval_q) begin
                done_q        <= 1'b1;
                pass_q        <= pass_d;
                frame_abort_q <= abort_q;
                frame_data_q  <= data_q;
                if (fifo_empty) underrun_q <= 1'b1;
                if (pass_d) begin
                    if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_WIDTH'(1);
                end else begin
                    if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_WIDTH'(1);
                end
            end

            if (clr_cnt_i) begin
                pass_cnt_q <= '0;
                fail_cnt_q <= '0;
                underrun_q <= 1'b0;
            end
        end
    end

    assign frame_done_o  = done_q;
    assign frame_pass_o  = pass_q;
    assign frame_abort_o = frame_abort_q;
    assign frame_data_o  = frame_data_q;
    assign pass_cnt_o    = pass_cnt_q;
    assign fail_cnt_o    = fail_cnt_q;
    assign underrun_o    = underrun_q;
endmodule

// File: tb/tb_uart_frame_checker.sv
// Directed bench: 8-bit counter instance plus a 2-bit counter instance on shared stimulus.
module tb_uart_frame_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, par_en, par_typ, exp_valid, ser_in, ser_vld, clr_cnt;
    logic [7:0] exp_data;

    logic       rdy_a, done_a, pass_a, abort_a, und_a;
    logic [4:0] cnt_a;
    logic [7:0] data_a, pcnt_a, fcnt_a;
    logic       rdy_b, done_b, pass_b, abort_b, und_b;
    logic [4:0] cnt_b;
    logic [7:0] data_b;
    logic [1:0] pcnt_b, fcnt_b;

    uart_frame_checker #(.DATA_WIDTH(8), .EXP_DEPTH(16), .CNT_WIDTH(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .par_en_i(par_en), .par_typ_i(par_typ),
        .exp_data_i(exp_data), .exp_valid_i(exp_valid), .exp_ready_o(rdy_a),
        .exp_count_o(cnt_a), .ser_in_i(ser_in), .ser_vld_i(ser_vld), .clr_cnt_i(clr_cnt),
        .frame_done_o(done_a), .frame_pass_o(pass_a), .frame_abort_o(abort_a),
        .frame_data_o(data_a), .pass_cnt_o(pcnt_a), .fail_cnt_o(fcnt_a), .underrun_o(und_a));

    uart_frame_checker #(.DATA_WIDTH(8), .EXP_DEPTH(16), .CNT_WIDTH(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .par_en_i(par_en), .par_typ_i(par_typ),
        .exp_data_i(exp_data), .exp_valid_i(exp_valid), .exp_ready_o(rdy_b),
        .exp_count_o(cnt_b), .ser_in_i(ser_in), .ser_vld_i(ser_vld), .clr_cnt_i(clr_cnt),
        .frame_done_o(done_b), .frame_pass_o(pass_b), .frame_abort_o(abort_b),
        .frame_data_o(data_b), .pass_cnt_o(pcnt_b), .fail_cnt_o(fcnt_b), .underrun_o(und_b));

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int done_n = 0;
    int done_cyc[$];
    int start_cyc;
    int idle_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (done_a === 1'b1) begin
            done_n++;
            done_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [7:0] d);
        @(negedge clk);
        exp_valid = 1'b1;
        exp_data  = d;
        @(negedge clk);
        exp_valid = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        ser_vld = 1'b1;
        ser_in  = b;
    endtask

    task automatic go_idle();
        @(negedge clk);
        ser_vld  = 1'b0;
        ser_in   = 1'b1;
        idle_cyc = cyc;
    endtask

    // Parity bit is only sent when par_en is set.
    task automatic send_frame(input logic [7:0] d, input logic pb);
        drive_bit(1'b0);
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_en) drive_bit(pb);
        drive_bit(1'b1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 40 && done_n < target; i++) @(negedge clk);
        check("done_count", done_n, target);
    endtask

    initial begin
        rst_n = 1'b0; par_en = 1'b0; par_typ = 1'b0; exp_valid = 1'b0;
        exp_data = 8'h00; ser_in = 1'b1; ser_vld = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_ready", 32'(rdy_a), 32'd1);
        check("rst_done",  32'(done_a), 32'd0);
        check("rst_outs",  {pass_a, abort_a, und_a, data_a, pcnt_a, fcnt_a}, 32'd0);
        rst_n = 1'b1;

        // Even parity 0xA5
        par_en = 1'b1; par_typ = 1'b0;
        push_word(8'hA5);
        send_frame(8'hA5, 1'b0);
        go_idle();
        wait_done(1);
        check("t1_latency", done_cyc[0] - start_cyc, 32'd12);
        check("t1_pass",  32'(pass_a), 32'd1);
        check("t1_data",  32'(data_a), 32'hA5);
        check("t1_pcnt",  32'(pcnt_a), 32'd1);
        check("t1_count", 32'(cnt_a), 32'd0);
        check("t1_pcnt_b", 32'(pcnt_b), 32'd1);
        @(negedge clk);
        check("t1_done_pulse", 32'(done_a), 32'd0);
        check("t1_pass_held",  32'(pass_a), 32'd1);

        // Odd parity, data mismatch (0x3D has correct odd parity 0)
        par_typ = 1'b1;
        push_word(8'h3C);
        send_frame(8'h3D, 1'b0);
        go_idle();
        wait_done(2);
        check("t2_pass",  32'(pass_a), 32'd0);
        check("t2_data",  32'(data_a), 32'h3D);
        check("t2_fcnt",  32'(fcnt_a), 32'd1);
        check("t2_count", 32'(cnt_a), 32'd0);
        check("t2_abort", 32'(abort_a), 32'd0);

        // No parity, three back-to-back frames
        par_en = 1'b0;
        push_word(8'h00); push_word(8'hFF); push_word(8'h81);
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        send_frame(8'h81, 1'b0);
        go_idle();
        wait_done(5);
        check("t3_gap1", done_cyc[3] - done_cyc[2], 32'd10);
        check("t3_gap2", done_cyc[4] - done_cyc[3], 32'd10);
        check("t3_pcnt", 32'(pcnt_a), 32'd4);
        check("t3_pcnt_b_sat", 32'(pcnt_b), 32'd3);
        check("t3_data", 32'(data_a), 32'h81);

        // Abort after 5 data bits of 0x55
        par_en = 1'b1; par_typ = 1'b0;
        push_word(8'h55);
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        go_idle();
        wait_done(6);
        check("t4_latency", done_cyc[5] - idle_cyc, 32'd2);
        check("t4_abort", 32'(abort_a), 32'd1);
        check("t4_pass",  32'(pass_a), 32'd0);
        check("t4_data",  32'(data_a), 32'h15);
        check("t4_fcnt",  32'(fcnt_a), 32'd2);
        check("t4_count", 32'(cnt_a), 32'd0);
        push_word(8'h5A);
        send_frame(8'h5A, 1'b0);
        go_idle();
        wait_done(7);
        check("t4b_pass",  32'(pass_a), 32'd1);
        check("t4b_abort", 32'(abort_a), 32'd0);
        check("t4b_pcnt",  32'(pcnt_a), 32'd5);

        // FIFO full / drain / underrun
        par_en = 1'b0;
        @(negedge clk);
        exp_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            exp_data = 8'(i * 3 + 1);
            if (i == 16) begin
                check("t5_ready_full", 32'(rdy_a), 32'd0);
                check("t5_count_full", 32'(cnt_a), 32'd16);
            end
            @(negedge clk);
        end
        exp_valid = 1'b0;
        check("t5_count_after", 32'(cnt_a), 32'd16);
        for (int i = 0; i < 16; i++) send_frame(8'(i * 3 + 1), 1'b0);
        go_idle();
        wait_done(23);
        check("t5_pcnt",  32'(pcnt_a), 32'd21);
        check("t5_count", 32'(cnt_a), 32'd0);
        check("t5_und0",  32'(und_a), 32'd0);
        send_frame(8'h11, 1'b0);
        go_idle();
        wait_done(24);
        check("t5_pass", 32'(pass_a), 32'd0);
        check("t5_und",  32'(und_a), 32'd1);
        check("t5_und_b", 32'(und_b), 32'd1);
        check("t5_fcnt", 32'(fcnt_a), 32'd3);

        // Clear, then saturation on the 2-bit instance
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        check("t6_clr", {und_a, und_b, pcnt_a, fcnt_a, 6'(pcnt_b), 6'(fcnt_b)}, 32'd0);
        push_word(8'h01); push_word(8'h02); push_word(8'h03); push_word(8'h04);
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0);
        go_idle();
        wait_done(28);
        check("t6_pcnt_b_sat", 32'(pcnt_b), 32'd3);
        check("t6_pcnt_a", 32'(pcnt_a), 32'd4);

        // Clear coinciding with FRAME_DONE: clear wins
        push_word(8'h10);
        send_frame(8'h10, 1'b0);
        @(negedge clk); ser_vld = 1'b0; clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        check("t6_coinc_done", 32'(done_a), 32'd1);
        check("t6_coinc_pass", 32'(pass_a), 32'd1);
        check("t6_coinc_pcnt", 32'(pcnt_a), 32'd0);

        // Reset mid-frame
        push_word(8'h77);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        @(negedge clk); ser_vld = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("t7_count", 32'(cnt_a), 32'd0);
        check("t7_ready", 32'(rdy_a), 32'd1);
        check("t7_outs",  {done_a, pass_a, abort_a, und_a, data_a, pcnt_a, fcnt_a}, 32'd0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("t7_no_done", done_n, 32'd29);
        check("t7_data_b", 32'(data_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
